// File: rtl/ram_burst_rd_if.sv
// Bus bundle for ram_burst_rd: control inputs, RAM read port and output stream.
// The slave modport is the controller side; master is the driver/consumer side.
interface ram_burst_rd_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              start;
   logic              auto_en;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   burst_len;
   logic              ram_rd_en;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic [DATA_W-1:0] ram_rd_data;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;
   logic              done;

   modport slave (
      input  start, auto_en, base_addr, burst_len, ram_rd_data,
      output ram_rd_en, ram_rd_addr, out_valid, out_data, out_last, busy, done
   );

   modport master (
      output start, auto_en, base_addr, burst_len, ram_rd_data,
      input  ram_rd_en, ram_rd_addr, out_valid, out_data, out_last, busy, done
   );
endinterface

// File: rtl/ram_burst_rd.sv
// Burst read controller: issues len consecutive (wrapping) RAM reads, realigns the
// data for the fixed RAM latency and emits a valid/last stream with a done pulse.
module ram_burst_rd #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int RD_LAT = 1,
   parameter int GAP    = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   ram_burst_rd_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_GAP} state_t;

   localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR1_C = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [2:0]        LAT_C   = 3'(RD_LAT);
   localparam logic [7:0]        GAP_C   = 8'(GAP);

   state_t            state_r;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W:0]   len_r;
   logic [ADDR_W:0]   cnt_r;
   logic              rd_en_r;
   logic              rd_last_r;
   logic [2:0]        drain_cnt_r;
   logic [7:0]        gap_cnt_r;
   logic              busy_r;
   logic              done_r;
   logic [RD_LAT-1:0] v_pipe_r;
   logic [RD_LAT-1:0] l_pipe_r;
   logic              out_valid_r;
   logic              out_last_r;
   logic [DATA_W-1:0] out_data_r;
   logic              len_ok_s;
   logic              accept_s;

   assign len_ok_s = (bus.burst_len != {(ADDR_W+1){1'b0}}) && (bus.burst_len <= DEPTH_C);
   assign accept_s = (bus.start | bus.auto_en) & len_ok_s;

   // Burst sequencing FSM with registered RAM request and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         addr_r      <= {ADDR_W{1'b0}};
         len_r       <= {(ADDR_W+1){1'b0}};
         cnt_r       <= {(ADDR_W+1){1'b0}};
         rd_en_r     <= 1'b0;
         rd_last_r   <= 1'b0;
         drain_cnt_r <= 3'd0;
         gap_cnt_r   <= 8'd0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  addr_r    <= bus.base_addr;
                  len_r     <= bus.burst_len;
                  cnt_r     <= ONE_C;
                  rd_en_r   <= 1'b1;
                  rd_last_r <= (bus.burst_len == ONE_C);
                  busy_r    <= 1'b1;
                  state_r   <= S_READ;
               end else begin
                  addr_r    <= {ADDR_W{1'b0}};
                  rd_en_r   <= 1'b0;
                  rd_last_r <= 1'b0;
                  busy_r    <= 1'b0;
               end
            end
            S_READ: begin
               // cnt_r is the number of requests already on the bus
               if (cnt_r == len_r) begin
                  addr_r      <= {ADDR_W{1'b0}};
                  rd_en_r     <= 1'b0;
                  rd_last_r   <= 1'b0;
                  drain_cnt_r <= 3'd0;
                  state_r     <= S_DRAIN;
               end else begin
                  addr_r    <= addr_r + ADDR1_C;
                  cnt_r     <= cnt_r + ONE_C;
                  rd_last_r <= ((cnt_r + ONE_C) == len_r);
               end
            end
            S_DRAIN: begin
               if (drain_cnt_r == LAT_C) begin
                  done_r <= 1'b1;
                  if (GAP > 0) begin
                     gap_cnt_r <= 8'd0;
                     state_r   <= S_GAP;
                  end else begin
                     busy_r  <= 1'b0;
                     state_r <= S_IDLE;
                  end
               end else begin
                  drain_cnt_r <= drain_cnt_r + 3'd1;
               end
            end
            S_GAP: begin
               // the done cycle plus GAP idle cycles before IDLE
               if (gap_cnt_r == GAP_C) begin
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r + 8'd1;
               end
            end
            default: begin
               addr_r  <= {ADDR_W{1'b0}};
               rd_en_r <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   // Valid/last pipe matching RAM latency, then capture into the output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_pipe_r    <= {RD_LAT{1'b0}};
         l_pipe_r    <= {RD_LAT{1'b0}};
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         out_data_r  <= {DATA_W{1'b0}};
      end else begin
         v_pipe_r[0] <= rd_en_r;
         l_pipe_r[0] <= rd_last_r;
         for (int i = 1; i < RD_LAT; i++) begin
            v_pipe_r[i] <= v_pipe_r[i-1];
            l_pipe_r[i] <= l_pipe_r[i-1];
         end
         out_valid_r <= v_pipe_r[RD_LAT-1];
         out_last_r  <= l_pipe_r[RD_LAT-1];
         if (v_pipe_r[RD_LAT-1]) begin
            out_data_r <= bus.ram_rd_data;
         end else begin
            out_data_r <= out_data_r;
         end
      end
   end

   assign bus.ram_rd_en   = rd_en_r;
   assign bus.ram_rd_addr = addr_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.out_data    = out_data_r;
   assign bus.out_last    = out_last_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
endmodule

// File: tb/tb_ram_burst_rd.sv
// Scoreboard bench for ram_burst_rd: instance A (RD_LAT=1, GAP=0) single-shot
// tests, instance B (RD_LAT=3, GAP=4) auto-repeat spacing.
module tb_ram_burst_rd;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   ram_burst_rd_if #(.DATA_W(8), .ADDR_W(5)) ia ();
   ram_burst_rd_if #(.DATA_W(8), .ADDR_W(5)) ib ();

   ram_burst_rd #(.DATA_W(8), .ADDR_W(5), .RD_LAT(1), .GAP(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
   ram_burst_rd #(.DATA_W(8), .ADDR_W(5), .RD_LAT(3), .GAP(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] mem_f(input logic [4:0] a);
      return {3'b000, a} + 8'h10;
   endfunction

   // RAM models: latency 1 for A, latency 3 for B
   logic [7:0] pa;
   logic [7:0] pb [3];
   always @(posedge clk) begin
      pa    <= mem_f(ia.ram_rd_addr);
      pb[0] <= mem_f(ib.ram_rd_addr);
      pb[1] <= pb[0];
      pb[2] <= pb[1];
   end
   assign ia.ram_rd_data = pa;
   assign ib.ram_rd_data = pb[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [8:0] qa[$];
   logic [8:0] qb[$];
   logic va_prev = 1'b0, vb_prev = 1'b0;
   int   first_a = 0, done_a_cnt = 0, done_a_cyc = 0, nbeat_a = 0;
   int   done_b_cnt = 0;
   int   fvb[$];

   // Output monitors: pop expected beats, log first-beat and done cycles.
   always @(negedge clk) begin
      va_prev <= ia.out_valid;
      vb_prev <= ib.out_valid;
      if (rst_n) begin
         if (ia.out_valid) begin
            nbeat_a <= nbeat_a + 1;
            if (!va_prev) first_a <= cyc;
            if (qa.size() == 0) chk("a_unexpected_beat", 32'd1, 32'd0);
            else chk("a_beat", {23'd0, ia.out_last, ia.out_data}, {23'd0, qa.pop_front()});
         end
         if (ia.done) begin
            done_a_cnt <= done_a_cnt + 1;
            done_a_cyc <= cyc;
         end
         if (ib.out_valid) begin
            if (!vb_prev) fvb.push_back(cyc);
            if (qb.size() == 0) chk("b_unexpected_beat", 32'd1, 32'd0);
            else chk("b_beat", {23'd0, ib.out_last, ib.out_data}, {23'd0, qb.pop_front()});
         end
         if (ib.done) begin
            done_b_cnt <= done_b_cnt + 1;
            chk("b_busy_in_done", {31'd0, ib.busy}, 32'd1);
         end
      end
   end

   task automatic kick(input logic [4:0] b, input logic [5:0] l, output int t);
      logic [4:0] a;
      @(negedge clk);
      ia.start = 1'b1;
      ia.base_addr = b;
      ia.burst_len = l;
      t = cyc;
      for (int k = 0; k < int'(l); k++) begin
         a = b + 5'(k);
         qa.push_back({(k == int'(l) - 1), mem_f(a)});
      end
      @(negedge clk);
      ia.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int t, input int len);
      int n = 0;
      int d0 = done_a_cnt;
      while (done_a_cnt == d0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk({tag, "_done_seen"}, 32'(done_a_cnt - d0), 32'd1);
      chk({tag, "_done_cyc"}, 32'(done_a_cyc - t), 32'(2 + len + 1));
      chk({tag, "_first_valid"}, 32'(first_a - t), 32'd3);
      @(negedge clk);
      chk({tag, "_busy_after"}, {31'd0, ia.busy}, 32'd0);
      chk({tag, "_done_single"}, {31'd0, ia.done}, 32'd0);
      chk({tag, "_all_beats"}, 32'(qa.size()), 32'd0);
   endtask

   task automatic illegal_len(input string tag, input logic [5:0] l);
      int seen = 0;
      @(negedge clk);
      ia.start = 1'b1;
      ia.burst_len = l;
      @(negedge clk);
      ia.start = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (ia.busy || ia.done || ia.ram_rd_en) seen++;
      end
      chk(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      int t, t0, b0, d0;
      ia.start = 1'b0; ia.auto_en = 1'b0; ia.base_addr = 5'd0; ia.burst_len = 6'd0;
      ib.start = 1'b0; ib.auto_en = 1'b0; ib.base_addr = 5'd0; ib.burst_len = 6'd0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({ia.ram_rd_en, ia.ram_rd_addr, ia.out_valid, ia.out_data,
                                ia.out_last, ia.busy, ia.done}), 32'd0);
      rst_n = 1'b1;

      kick(5'd0, 6'd32, t);
      wait_done("full32", t, 32);

      kick(5'd30, 6'd4, t);
      wait_done("wrap", t, 4);

      kick(5'd7, 6'd1, t);
      wait_done("len1", t, 1);

      illegal_len("len0_ignored", 6'd0);
      illegal_len("len33_ignored", 6'd33);

      // requests and base/len changes while busy must not disturb the burst
      kick(5'd5, 6'd8, t);
      repeat (4) begin
         ia.start = 1'b1;
         ia.base_addr = 5'd20;
         ia.burst_len = 6'd3;
         @(negedge clk);
      end
      ia.start = 1'b0;
      wait_done("busy_ignore", t, 8);

      // asynchronous reset with beats in flight
      kick(5'd0, 6'd16, t);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", 32'({ia.ram_rd_en, ia.ram_rd_addr, ia.out_valid, ia.out_data,
                                      ia.out_last, ia.busy, ia.done}), 32'd0);
      qa.delete();
      @(negedge clk);
      rst_n = 1'b1;
      b0 = nbeat_a;
      d0 = done_a_cnt;
      repeat (20) @(negedge clk);
      @(posedge clk);
      chk("post_reset_beats", 32'(nbeat_a - b0), 32'd0);
      chk("post_reset_done", 32'(done_a_cnt - d0), 32'd0);
      kick(5'd2, 6'd3, t);
      wait_done("after_reset", t, 3);

      // auto-repeat on B: three bursts, auto_en dropped during the third
      @(negedge clk);
      ib.base_addr = 5'd3;
      ib.burst_len = 6'd2;
      for (int r = 0; r < 3; r++) begin
         qb.push_back({1'b0, mem_f(5'd3)});
         qb.push_back({1'b1, mem_f(5'd4)});
      end
      ib.auto_en = 1'b1;
      t0 = cyc;
      repeat (25) @(negedge clk);
      ib.auto_en = 1'b0;
      repeat (40) @(negedge clk);
      chk("auto_bursts", 32'(fvb.size()), 32'd3);
      if (fvb.size() >= 3) begin
         chk("auto_first_latency", 32'(fvb[0] - t0), 32'd5);
         chk("auto_spacing1", 32'(fvb[1] - fvb[0]), 32'd12);
         chk("auto_spacing2", 32'(fvb[2] - fvb[1]), 32'd12);
      end
      chk("auto_done_count", 32'(done_b_cnt), 32'd3);
      chk("auto_all_beats", 32'(qb.size()), 32'd0);
      chk("auto_idle_after", {31'd0, ib.busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
